// File: rtl/output_result_buffer_pkg.sv
// Shared defaults and lane helpers for the double-buffered Skein result buffer.
package output_result_buffer_pkg;

  localparam int DEF_LANES  = 16;
  localparam int DEF_LANE_W = 64;
  localparam int DEF_CNT_W  = 32;

  // Extract lane k from a word laid out as lane k = word[k*LANE_W +: LANE_W].
  function automatic logic [DEF_LANE_W-1:0] lane_slice(
    input logic [DEF_LANES*DEF_LANE_W-1:0] word,
    input int unsigned                     k
  );
    return word[k*DEF_LANE_W +: DEF_LANE_W];
  endfunction

endpackage

// File: rtl/output_bank.sv
// One result bank: per-lane data registers, fill mask, full flag and completion detect.
module output_bank
  import output_result_buffer_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en,
  input  logic [LANES-1:0]        write_bits,
  input  logic [LANES*LANE_W-1:0] lane_data,
  input  logic                    pop,
  output logic [LANES*LANE_W-1:0] data,
  output logic [LANES-1:0]        mask,
  output logic                    full,
  output logic                    complete
);

  // Completion looks at the strobes of the accepting cycle, so a full-strobe write completes alone.
  assign complete = wr_en && (&(mask | write_bits));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data <= '0;
      mask <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < LANES; k++) begin
          if (write_bits[k]) begin
            data[k*LANE_W +: LANE_W] <= lane_data[k*LANE_W +: LANE_W];
          end
        end
        if (complete) begin
          full <= 1'b1;
          mask <= '0;
        end else begin
          mask <= mask | write_bits;
        end
      end
      if (pop) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/output_result_buffer.sv
// Double-buffered Skein result collector: lanes fill one bank while the other is offered downstream.
module output_result_buffer
  import output_result_buffer_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [LANES-1:0]        write_bits_i,
  input  logic [LANES*LANE_W-1:0] input_i,
  output logic [LANES*LANE_W-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [LANES-1:0]        fill_mask_o,
  output logic [CNT_W-1:0]        pop_count_o
);

  logic [1:0][LANES*LANE_W-1:0] bank_data;
  logic [1:0][LANES-1:0]        bank_mask;
  logic [1:0]                   bank_full;
  logic [1:0]                   bank_complete;
  logic [1:0]                   bank_wr_en;
  logic [1:0]                   bank_pop;

  logic wr_sel;
  logic rd_sel;
  logic accept;
  logic pop;
  logic complete;

  // Handshake: a word transfers on any cycle where valid_o && ready_i; valid_o never
  // depends on ready_i, and data_o is held stable until that transfer happens.
  assign busy_o      = bank_full[wr_sel];
  assign valid_o     = bank_full[rd_sel];
  assign data_o      = bank_data[rd_sel];
  assign fill_mask_o = bank_mask[wr_sel];

  assign accept   = !busy_o;
  assign pop      = valid_o && ready_i;
  assign complete = bank_complete[wr_sel];

  assign bank_wr_en[0] = accept && !wr_sel;
  assign bank_wr_en[1] = accept && wr_sel;
  assign bank_pop[0]   = pop && !rd_sel;
  assign bank_pop[1]   = pop && rd_sel;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    output_bank #(
      .LANES (LANES),
      .LANE_W(LANE_W)
    ) u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en     (bank_wr_en[b]),
      .write_bits(write_bits_i),
      .lane_data (input_i),
      .pop       (bank_pop[b]),
      .data      (bank_data[b]),
      .mask      (bank_mask[b]),
      .full      (bank_full[b]),
      .complete  (bank_complete[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      overflow_o  <= 1'b0;
      pop_count_o <= '0;
    end else begin
      if (complete) begin
        wr_sel <= !wr_sel;
      end
      if (pop) begin
        rd_sel      <= !rd_sel;
        pop_count_o <= pop_count_o + 1'b1;
      end
      if (busy_o && (|write_bits_i)) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_result_buffer.sv
// Directed self-checking bench for output_result_buffer with hand-computed expectations.
module tb_output_result_buffer;
  import output_result_buffer_pkg::*;

  localparam int LANES  = DEF_LANES;
  localparam int LANE_W = DEF_LANE_W;
  localparam int CNT_W  = DEF_CNT_W;

  logic                    clk_i;
  logic                    rst_i;
  logic [LANES-1:0]        write_bits_i;
  logic [LANES*LANE_W-1:0] input_i;
  logic [LANES*LANE_W-1:0] data_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    busy_o;
  logic                    overflow_o;
  logic [LANES-1:0]        fill_mask_o;
  logic [CNT_W-1:0]        pop_count_o;

  int checks;
  int errors;

  output_result_buffer #(
    .LANES (LANES),
    .LANE_W(LANE_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .write_bits_i(write_bits_i),
    .input_i     (input_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .fill_mask_o (fill_mask_o),
    .pop_count_o (pop_count_o)
  );

  // Clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [LANES*LANE_W-1:0] make_word(input logic [63:0] base);
    logic [LANES*LANE_W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) w[k*LANE_W +: LANE_W] = base + 64'(k);
    return w;
  endfunction

  task automatic do_reset();
    rst_i        = 1'b1;
    write_bits_i = '0;
    input_i      = '0;
    ready_i      = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic write(input logic [LANES-1:0] bits, input logic [LANES*LANE_W-1:0] d);
    write_bits_i = bits;
    input_i      = d;
    tick();
    write_bits_i = '0;
    input_i      = '0;
  endtask

  initial begin
    logic [LANES*LANE_W-1:0] w;
    checks = 0;
    errors = 0;
    rst_i = 1'b1; write_bits_i = '0; input_i = '0; ready_i = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_mask", 64'(fill_mask_o), 64'd0);
    check("rst_pops", 64'(pop_count_o), 64'd0);
    check("rst_data_l0", lane_slice(data_o, 0), 64'd0);
    rst_i = 1'b0;

    // Single full-strobe word, lane k = k+1
    write(16'hFFFF, make_word(64'd1));
    check("t1_valid", 64'(valid_o), 64'd1);
    check("t1_lane5", lane_slice(data_o, 5), 64'd6);
    check("t1_lane15", lane_slice(data_o, 15), 64'd16);
    check("t1_mask", 64'(fill_mask_o), 64'd0);
    check("t1_busy", 64'(busy_o), 64'd0);

    // Incremental fill with a rewrite of lane 3
    do_reset();
    write(16'h00FF, make_word(64'h10));
    check("t2_mask_lo", 64'(fill_mask_o), 64'h00FF);
    check("t2_valid_lo", 64'(valid_o), 64'd0);
    w = '0;
    w[3*LANE_W +: LANE_W] = 64'hAA;
    write(16'h0008, w);
    check("t2_mask_mid", 64'(fill_mask_o), 64'h00FF);
    check("t2_valid_mid", 64'(valid_o), 64'd0);
    write(16'hFF00, make_word(64'h10));
    check("t2_valid", 64'(valid_o), 64'd1);
    check("t2_lane3", lane_slice(data_o, 3), 64'hAA);
    check("t2_lane2", lane_slice(data_o, 2), 64'h12);
    check("t2_lane8", lane_slice(data_o, 8), 64'h18);
    check("t2_mask_done", 64'(fill_mask_o), 64'd0);

    // Fill both banks with ready low, then overflow
    do_reset();
    write(16'hFFFF, make_word(64'h100));
    check("t3_busy1", 64'(busy_o), 64'd0);
    write(16'hFFFF, make_word(64'h200));
    check("t3_busy2", 64'(busy_o), 64'd1);
    check("t3_ovf_pre", 64'(overflow_o), 64'd0);
    write(16'h0001, make_word(64'h300));
    check("t3_ovf", 64'(overflow_o), 64'd1);
    check("t3_mask", 64'(fill_mask_o), 64'd0);
    check("t3_head", lane_slice(data_o, 0), 64'h100);

    // Drain both words in order
    ready_i = 1'b1;
    tick();
    check("t4_pop1_cnt", 64'(pop_count_o), 64'd1);
    check("t4_pop1_valid", 64'(valid_o), 64'd1);
    check("t4_pop1_data", lane_slice(data_o, 0), 64'h200);
    check("t4_pop1_busy", 64'(busy_o), 64'd0);
    tick();
    ready_i = 1'b0;
    check("t4_cnt", 64'(pop_count_o), 64'd2);
    check("t4_valid", 64'(valid_o), 64'd0);
    check("t4_busy", 64'(busy_o), 64'd0);
    check("t4_ovf", 64'(overflow_o), 64'd1);

    // Sustained throughput: full word every cycle with ready high
    do_reset();
    ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      write_bits_i = 16'hFFFF;
      input_i      = make_word(64'h1000 * i);
      tick();
      check($sformatf("t5_valid_%0d", i), 64'(valid_o), 64'd1);
      check($sformatf("t5_data_%0d", i), lane_slice(data_o, 0), 64'h1000 * i);
    end
    write_bits_i = '0;
    input_i      = '0;
    ready_i      = 1'b0;
    check("t5_cnt", 64'(pop_count_o), 64'd9);
    check("t5_ovf", 64'(overflow_o), 64'd0);
    check("t5_busy", 64'(busy_o), 64'd0);

    // Reset mid-fill discards partial word and clears everything
    write(16'h0F0F, make_word(64'h55));
    check("t6_mask_pre", 64'(fill_mask_o), 64'h0F0F);
    do_reset();
    check("t6_mask", 64'(fill_mask_o), 64'd0);
    check("t6_data", lane_slice(data_o, 0), 64'd0);
    check("t6_valid", 64'(valid_o), 64'd0);
    check("t6_ovf", 64'(overflow_o), 64'd0);
    check("t6_cnt", 64'(pop_count_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_result_buffer.md
# output_result_buffer

Parametrised, double-buffered successor to the 16×64-bit output register block. Collects Skein output state lane-by-lane under per-lane write strobes into a fill bank. Once every lane has been written, it publishes the complete word to downstream logic over a valid/ready handshake, while a second result fills the other bank. It sits between the Skein round pipeline and the hash comparator/host readout.

## Interface
Parameters:
- LANES, 16, number of lanes per result word
- LANE_W, 64, bits per lane
- CNT_W, 32, width of the popped-result counter

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- write_bits_i  in  LANES  per-lane write strobes; bit k writes lane k
- input_i  in  LANES*LANE_W  lane data; lane k = input_i[k*LANE_W +: LANE_W]
- data_o  out  LANES*LANE_W  word of the read bank; reset 0
- valid_o  out  1  read bank holds a complete word; reset 0
- ready_i  in  1  consumer accepts data_o this cycle
- busy_o  out  1  both banks full, writes are dropped; reset 0
- overflow_o  out  1  sticky: a write was dropped; reset 0
- fill_mask_o  out  LANES  lanes written so far in the fill bank; reset 0
- pop_count_o  out  CNT_W  number of accepted words, wraps modulo 2^CNT_W; reset 0

## Operation
- State:
  - two banks B0/B1, each holding LANES×LANE_W data, a LANES-bit mask and a full flag
  - wr_sel selects the fill bank; rd_sel selects the read bank; both reset to 0
- Lane write, when busy_o=0: for each asserted bit k, fill-bank lane k ← input_i lane k and mask[k] ← 1. Re-writing an already-set lane overwrites the data; the mask is unchanged.
- Completion:
  - Condition: (mask | write_bits_i) is all ones in a cycle where the write is accepted.
  - Effect: fill bank full ← 1, its mask ← 0, wr_sel toggles.
  - A single cycle with write_bits_i all ones completes a word by itself.
- valid_o = full[rd_sel]; data_o = data[rd_sel].
- Pop: valid_o & ready_i → full[rd_sel] ← 0, rd_sel toggles, pop_count_o +1. A pop does not alter the bank data.
- busy_o = full[wr_sel], which means both banks are full.
  - While busy_o=1, write_bits_i is ignored entirely.
  - Any nonzero write_bits_i while busy_o=1 sets overflow_o. overflow_o is cleared only by rst_i.
- Simultaneous completion and pop:
  - They act on different banks, so both take effect.
  - A pop in a busy_o=1 cycle frees a bank from the next cycle onward; writes in that same cycle are still dropped.
- fill_mask_o = mask[wr_sel].
- Reset mid-fill or mid-handshake: all state clears in the same edge, and partial words are discarded.

## Timing
- Completing write at edge N → valid_o=1 after edge N, when the other bank was empty.
- Pop at edge N → valid_o reflects the other bank's full flag after edge N. Back-to-back pops are possible when both banks are full.
- Throughput: one word per cycle sustained when writes use all strobes and ready_i=1.
- No combinational path from ready_i or write_bits_i to any output; all outputs are decoded from registers.

## Structure
- Package output_result_buffer_pkg: default LANES, LANE_W, CNT_W constants and a lane-slice helper function.
- Sub-module output_bank: one bank of LANES lane registers with mask, full flag, complete detection and clear. It is instantiated twice.
- The top level holds wr_sel, rd_sel, overflow, the pop counter and the output mux.

## Test plan
- Reset, then write_bits_i=16'hFFFF with lane k=k+1 → next cycle valid_o=1, data_o lane 5=6, fill_mask_o=0, busy_o=0.
- Incremental fill, strobes 0x00FF then 0xFF00 with lane 3 rewritten to 0xAA in a middle cycle:
  - fill_mask_o reads 0x00FF after the first write
  - valid_o rises one cycle after the 0xFF00 write
  - lane 3 = 0xAA
- ready_i=0, two full words written → busy_o=1. A third write (0x0001) → overflow_o=1 and fill_mask_o stays 0.
- Continuing from the previous case, ready_i=1 for 2 cycles → words popped in order, pop_count_o=2, valid_o=0, busy_o=0. overflow_o stays 1.
- Full-strobe writes every cycle with ready_i=1 for 10 cycles → valid_o=1 continuously from cycle 1, pop_count_o=9 after cycle 10, overflow_o=0.
- Partial fill 0x0F0F, then rst_i high for 1 cycle → fill_mask_o=0, data_o=0, valid_o=0, overflow_o=0, pop_count_o=0.
